// File: rtl/dff_reg_arbiter_if.sv
// Request/grant bus between the requesters and the shared-register write arbiter.
// The master drives requests and data; the slave (arbiter) returns grant, acknowledge and register state.
interface dff_reg_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       q;
    logic                   busy;
    logic [7:0]             wr_count;

    modport master (
        output req, wdata,
        input  gnt, done, q, busy, wr_count
    );

    modport slave (
        input  req, wdata,
        output gnt, done, q, busy, wr_count
    );
endinterface

// File: rtl/dff_reg_arbiter.sv
// Round-robin write scheduler for the shared register: IDLE -> GRANT -> ACK per write,
// one requester at a time, priority rotating past the last winner.
module dff_reg_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    dff_reg_arbiter_if.slave   io_bus
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_ptr,   w_next_ptr;
    logic [PTR_W-1:0]   r_win,   w_next_win;
    logic [N_REQ-1:0]   r_gnt,   w_next_gnt;
    logic [N_REQ-1:0]   r_done,  w_next_done;
    logic [WIDTH-1:0]   r_q,     w_next_q;
    logic [CNT_W-1:0]   r_cnt,   w_next_cnt;
    logic               r_busy,  w_next_busy;

    logic               w_found;
    logic [PTR_W-1:0]   w_arb_win;
    logic [WIDTH-1:0]   w_sel_data;

    // Scan requests starting at ptr, wrapping modulo N_REQ; first set bit wins.
    always_comb begin
        int unsigned idx;
        w_found   = 1'b0;
        w_arb_win = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(r_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && io_bus.req[PTR_W'(idx)]) begin
                w_found   = 1'b1;
                w_arb_win = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_win == PTR_W'(i)) begin
                w_sel_data = io_bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_win   = r_win;
        w_next_gnt   = r_gnt;
        w_next_done  = r_done;
        w_next_q     = r_q;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_next_gnt = '0;
                if (w_found) begin
                    w_next_win   = w_arb_win;
                    w_next_gnt   = N_REQ'(1) << w_arb_win;
                    w_next_state = S_GRANT;
                end
            end
            S_GRANT: begin
                // Commit regardless of whether req[w] is still high.
                w_next_q     = w_sel_data;
                w_next_done  = N_REQ'(1) << r_win;
                w_next_cnt   = r_cnt + CNT_W'(1);
                w_next_state = S_ACK;
            end
            S_ACK: begin
                w_next_gnt   = '0;
                w_next_done  = '0;
                w_next_ptr   = (r_win == PTR_W'(N_REQ - 1)) ? '0 : r_win + PTR_W'(1);
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_gnt   = '0;
                w_next_done  = '0;
                w_next_state = S_IDLE;
            end
        endcase
        w_next_busy = (w_next_state != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
            r_win   <= w_next_win;
            r_gnt   <= w_next_gnt;
            r_done  <= w_next_done;
            r_q     <= w_next_q;
            r_cnt   <= w_next_cnt;
            r_busy  <= w_next_busy;
        end
    end

    assign io_bus.gnt      = r_gnt;
    assign io_bus.done     = r_done;
    assign io_bus.q        = r_q;
    assign io_bus.busy     = r_busy;
    assign io_bus.wr_count = r_cnt;
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dff_reg_arbiter;
    localparam int NR = 4;
    localparam int W  = 8;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   started = 0;

    dff_reg_arbiter_if #(.N_REQ(NR), .WIDTH(W)) bus ();

    dff_reg_arbiter #(.N_REQ(NR), .WIDTH(W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return 0;
    endfunction

    // Reference model: a write is a 3-cycle transaction (granted, acknowledged, released).
    int m_stage, m_ptr, m_win, m_q, m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stage <= 0; m_ptr <= 0; m_win <= 0; m_q <= 0; m_cnt <= 0;
        end else begin
            case (m_stage)
                0: if (bus.req != '0) begin
                       m_win   <= rr(bus.req, m_ptr);
                       m_stage <= 1;
                   end
                1: begin
                       m_q     <= int'(bus.wdata[m_win*W +: W]);
                       m_cnt   <= (m_cnt + 1) % 256;
                       m_stage <= 2;
                   end
                default: begin
                       m_ptr   <= (m_win + 1) % NR;
                       m_stage <= 0;
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("gnt",      32'(bus.gnt),      (m_stage != 0) ? (32'd1 << m_win) : 32'd0);
            chk("done",     32'(bus.done),     (m_stage == 2) ? (32'd1 << m_win) : 32'd0);
            chk("q",        32'(bus.q),        32'(m_q));
            chk("busy",     32'(bus.busy),     32'(m_stage != 0));
            chk("wr_count", 32'(bus.wr_count), 32'(m_cnt));
        end
    end

    // Caller sits at a negedge; reset is asserted and released away from either edge.
    task automatic pulse_rst(input bit clr_req);
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt",  32'(bus.gnt),      32'd0);
        chk("rst_done", 32'(bus.done),     32'd0);
        chk("rst_q",    32'(bus.q),        32'd0);
        chk("rst_cnt",  32'(bus.wr_count), 32'd0);
        chk("rst_busy", 32'(bus.busy),     32'd0);
        @(negedge clk);
        if (clr_req) bus.req = '0;
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        started = 1;

        // Random activity, then asynchronous reset mid-cycle
        repeat (8) begin
            @(negedge clk);
            bus.req   = NR'($urandom_range(0, 15));
            bus.wdata = {$urandom};
        end
        @(negedge clk);
        pulse_rst(1);

        // Single requester
        @(negedge clk);
        bus.req = 4'b0100;
        bus.wdata[2*W +: W] = 8'hA5;
        @(negedge clk);
        chk("single_gnt", 32'(bus.gnt), 32'h4);
        chk("single_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("single_q", 32'(bus.q), 32'hA5);
        chk("single_done", 32'(bus.done), 32'h4);
        chk("single_cnt", 32'(bus.wr_count), 32'd1);
        bus.req = '0;
        @(negedge clk);
        chk("single_idle", 32'(bus.busy), 32'd0);
        pulse_rst(1);

        // Contention with all four requesting, then rotation with 1001
        @(negedge clk);
        bus.req = 4'b1111;
        for (int i = 0; i < NR; i++) bus.wdata[i*W +: W] = 8'(8'h10 + i);
        for (int t = 0; t < NR; t++) begin
            @(negedge clk);
            chk("cont_gnt", 32'(bus.gnt), 32'd1 << t);
            @(negedge clk);
            chk("cont_q", 32'(bus.q), 32'(8'h10 + t));
            chk("cont_done", 32'(bus.done), 32'd1 << t);
            if (t == NR - 1) bus.req = 4'b1001;
            @(negedge clk);
            chk("cont_done_1cyc", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        chk("rot_gnt0", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        chk("rot_q0", 32'(bus.q), 32'h10);
        @(negedge clk);
        @(negedge clk);
        chk("rot_gnt3", 32'(bus.gnt), 32'h8);
        @(negedge clk);
        chk("rot_q3", 32'(bus.q), 32'h13);
        bus.req = '0;
        @(negedge clk);

        // Reset during GRANT for requester 1
        bus.req = 4'b0010;
        bus.wdata[1*W +: W] = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        chk("mid_q3c", 32'(bus.q), 32'h3C);
        bus.wdata[1*W +: W] = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        chk("mid_gnt", 32'(bus.gnt), 32'h2);
        pulse_rst(0);
        @(negedge clk);
        chk("mid_regnt", 32'(bus.gnt), 32'h2);
        @(negedge clk);
        chk("mid_qff", 32'(bus.q), 32'hFF);
        chk("mid_cnt", 32'(bus.wr_count), 32'd1);
        bus.req = '0;
        repeat (2) @(negedge clk);
        pulse_rst(1);

        // 256 back-to-back writes wrap the counter
        @(negedge clk);
        bus.req = 4'b0001;
        for (int c = 1; c <= 767; c++) begin
            @(negedge clk);
            bus.wdata[0 +: W] = 8'($urandom);
            if (c == 764) chk("wrap_255", 32'(bus.wr_count), 32'd255);
            if (c == 767) begin
                chk("wrap_0", 32'(bus.wr_count), 32'd0);
                chk("wrap_done", 32'(bus.done), 32'h1);
                bus.req = '0;
            end
        end
        repeat (2) @(negedge clk);

        // Request dropped during GRANT still commits
        bus.req = 4'b0010;
        bus.wdata[1*W +: W] = 8'h5A;
        @(negedge clk);
        chk("drop_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        @(negedge clk);
        chk("drop_q", 32'(bus.q), 32'h5A);
        chk("drop_done", 32'(bus.done), 32'h2);
        chk("drop_cnt", 32'(bus.wr_count), 32'd1);
        @(negedge clk);
        chk("drop_idle", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
